uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO. It replaces the single-word, one-cycle-per-bit transmitter. It adds configurable data width, a baud prescaler, optional two stop bits and a queued valid/ready input. Frames are sent back-to-back with no idle gap while the FIFO holds data. It sits between the system-side byte producer and the serial TX pin.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9)
- FIFO_DEPTH, 4, words buffered (power of 2, ≥2)
- PRESCALE_W, 8, width of the Prescale input
- CLK  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- P_data  in  DATA_WIDTH  word to transmit
- Data_valid  in  1  write request
- Data_ready  out  1  FIFO not full; a write is accepted on an edge where Data_valid && Data_ready
- PAR_EN  in  1  parity bit enable
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP2  in  1  0 = one stop bit, 1 = two stop bits
- Prescale  in  PRESCALE_W  bit period = Prescale+1 clocks
- Tx_out  out  1  serial line, idle high, LSB first
- Busy  out  1  frame in progress
- Fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in FIFO

## Operation
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Write when Data_valid && Data_ready.
  - Pop only by the FSM at frame start.
  - Push and pop on the same edge leave the count unchanged.
  - Data_valid while full is ignored; the word is not stored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Frame launch:
  - On an edge where the FSM is in IDLE (or ending its final stop bit) and Fifo_count != 0:
    - pop the word into the shift register;
    - latch PAR_EN, PAR_TYP, STOP2 and Prescale;
    - compute the parity bit;
    - go to START.
  - Configuration inputs have no effect on a frame already launched.
- States and outputs:
  - START: Tx_out = 0.
  - DATA: DATA_WIDTH bits, LSB first.
  - PARITY: present only if the latched PAR_EN = 1.
    - Even: bit = ^data.
    - Odd: bit = ~^data.
  - STOP: Tx_out = 1 for 1 bit, or 2 bits if the latched STOP2 = 1.
- Bit timing:
  - Each bit is held for exactly Prescale+1 clocks, timed by a down-counter reloaded at every bit boundary.
  - A bit counter tracks DATA and STOP progress.
- End of the final stop bit:
  - FIFO non-empty: launch the next frame directly (no idle clock); Busy stays 1.
  - FIFO empty: go to IDLE.
- Tx_out and Busy are registered.
- Busy = 1 in START through STOP, 0 in IDLE.

## Timing
- Reset values (applied on the edge where rst = 1):
  - Tx_out = 1, Busy = 0, Data_ready = 1, Fifo_count = 0.
  - FSM in IDLE, FIFO pointers cleared.
- Reset mid-frame: the frame is aborted and queued words are discarded. Tx_out = 1 and Busy = 0 after that edge.
- Latency: a word accepted at edge E0 into an empty FIFO while idle is popped at edge E1. Tx_out = 0 and Busy = 1 from E1.
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) × (Prescale+1) clocks.
- Data_ready is derived from the registered count. It deasserts the clock after the FIFO becomes full and reasserts the clock after a pop.
- Prescale = 0 gives one clock per bit. This is the default regression mode.

## Test plan
- Prescale=0, PAR_EN=0, STOP2=0, write 0x81 → Tx_out from E1: 0,1,0,0,0,0,0,0,1,1, one clock each. Busy high 10 clocks, then Tx_out=1, Busy=0.
- Prescale=3, PAR_EN=1, PAR_TYP=1, write 0x81 → bits 0,1,0,0,0,0,0,0,1,1,1 (parity 1, stop 1), each 4 clocks. Busy high 44 clocks.
- Prescale=0, PAR_EN=1, PAR_TYP=0, STOP2=1, write 0x86 → bits 0,0,1,1,0,0,0,0,1,1,1,1 (parity 1, two stops). Busy high 12 clocks.
- Depth 4, Prescale=0: hold Data_valid for 6 consecutive clocks with 0x7F,0x86,0x55,0xAA,0x11,0x22.
  - First 5 are accepted (first popped at E1, then 4 stored); Fifo_count reaches 4 and Data_ready=0.
  - 0x22 is not accepted.
  - 5 frames follow back-to-back with no idle clock between stop and start; Busy stays high for 50 clocks.
- Write 0x55 with Prescale=1, PAR_EN=0; during data bit 2 set PAR_EN=1, Prescale=5 → current frame unchanged (10 bits × 2 clocks). A next word written afterwards uses parity and 6-clock bits.
- Queue 3 words and assert rst for one clock during the first frame's data bit 3 → next edge: Tx_out=1, Busy=0, Fifo_count=0, Data_ready=1. No further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular FIFO. Frames go out LSB first with
// optional parity and one or two stop bits; queued words are sent back-to-back.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         P_data,
  input  logic                          Data_valid,
  output logic                          Data_ready,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESCALE_W-1:0]         Prescale,
  output logic                          Tx_out,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_count,
  output logic [2:0]                    state_dbg
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(DATA_WIDTH + 1);

  // Handshake: a word is written on any rising edge where Data_valid && Data_ready;
  // Data_ready depends only on the registered count, never on Data_valid.

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head;

  state_t                state;
  logic [PRESCALE_W-1:0] tick_cnt;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  lat_par_en;
  logic                  lat_stop2;
  logic [PRESCALE_W-1:0] lat_pre;
  logic                  bit_end;
  logic                  last_stop;
  logic                  launch;

  assign Data_ready = (Fifo_count != CW'(FIFO_DEPTH));
  assign push       = Data_valid && Data_ready;
  assign head       = mem[rd_ptr];
  assign state_dbg  = state;

  assign bit_end   = (tick_cnt == '0);
  assign last_stop = (state == STOP) && bit_end && (bit_cnt == BCW'(lat_stop2));
  // Launching from the final stop bit is what removes the idle gap between frames.
  assign launch    = (Fifo_count != '0) && ((state == IDLE) || last_stop);
  assign pop       = launch;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= P_data;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   Fifo_count <= Fifo_count + CW'(1);
        2'b01:   Fifo_count <= Fifo_count - CW'(1);
        default: Fifo_count <= Fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= IDLE;
      Tx_out     <= 1'b1;
      Busy       <= 1'b0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      lat_par_en <= 1'b0;
      lat_stop2  <= 1'b0;
      lat_pre    <= '0;
    end else if (launch) begin
      // Configuration is captured here so mid-frame changes only affect later frames.
      shreg      <= head;
      par_bit    <= PAR_TYP ? ~^head : ^head;
      lat_par_en <= PAR_EN;
      lat_stop2  <= STOP2;
      lat_pre    <= Prescale;
      tick_cnt   <= Prescale;
      bit_cnt    <= '0;
      state      <= START;
      Tx_out     <= 1'b0;
      Busy       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          Tx_out <= 1'b1;
          Busy   <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            tick_cnt <= lat_pre;
            bit_cnt  <= '0;
            Tx_out   <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            tick_cnt <= tick_cnt - PRESCALE_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            tick_cnt <= lat_pre;
            if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              if (lat_par_en) begin
                Tx_out <= par_bit;
                state  <= PARITY;
              end else begin
                Tx_out <= 1'b1;
                state  <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
              Tx_out  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            tick_cnt <= tick_cnt - PRESCALE_W'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            tick_cnt <= lat_pre;
            bit_cnt  <= '0;
            Tx_out   <= 1'b1;
            state    <= STOP;
          end else begin
            tick_cnt <= tick_cnt - PRESCALE_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            tick_cnt <= lat_pre;
            if (last_stop) begin
              state  <= IDLE;
              Busy   <= 1'b0;
              Tx_out <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end else begin
            tick_cnt <= tick_cnt - PRESCALE_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          Tx_out <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized bench for uart_tx_fifo: a per-clock expected line
// waveform is built from word/config values and compared on falling edges.
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] P_data = '0;
  logic          Data_valid = 1'b0;
  logic          Data_ready;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic [PW-1:0] Prescale = '0;
  logic          Tx_out;
  logic          Busy;
  logic [CW-1:0] Fifo_count;
  logic [2:0]    state_dbg;

  // Expected per-clock line values, each entry {busy, tx}.
  logic [1:0]    exp_q[$];
  logic [DW-1:0] wbuf[8];
  int            tests = 0;
  int            fails = 0;

  uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_W(PW)) dut (
    .CLK(CLK), .rst(rst), .P_data(P_data), .Data_valid(Data_valid),
    .Data_ready(Data_ready), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .Prescale(Prescale), .Tx_out(Tx_out), .Busy(Busy), .Fifo_count(Fifo_count),
    .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, 1 or 2 stops,
  // every bit repeated pre+1 clocks with Busy high.
  function automatic void add_frame(input logic [DW-1:0] w, input bit pe, input bit pt,
                                    input bit s2, input int pre);
    int ones = 0;
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (pe) bits.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int r = 0; r <= pre; r++) exp_q.push_back({1'b1, bits[i]});
    end
  endfunction

  task automatic tick(input string tag);
    logic [1:0] e;
    @(negedge CLK);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 2'b01;
    chk({tag, "_busy"}, 16'(Busy), 16'(e[1]));
    chk({tag, "_tx"}, 16'(Tx_out), 16'(e[0]));
  endtask

  task automatic chk_fifo(input string tag, input int cnt);
    chk({tag, "_count"}, 16'(Fifo_count), 16'(cnt));
    chk({tag, "_ready"}, 16'(Data_ready), 16'(cnt != DEPTH));
  endtask

  // Holds Data_valid for n consecutive clocks starting from an idle DUT with an
  // empty FIFO. The first word is popped one edge after it is written, so the
  // count only starts climbing from the third write; at most DEPTH+1 words fit.
  task automatic send_burst(input int n, input bit pe, input bit pt, input bit s2, input int pre);
    int ck;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    STOP2    = s2;
    Prescale = PW'(pre);
    for (int k = 0; k < n; k++) begin
      tick("burst");
      if (k >= 1) begin
        ck = (k == 1) ? 1 : k - 1;
        if (ck > DEPTH) ck = DEPTH;
        chk_fifo("burst", ck);
      end
      if (k == 0) exp_q.push_back(2'b01);
      P_data     = wbuf[k];
      Data_valid = 1'b1;
      if (k < DEPTH + 1) add_frame(wbuf[k], pe, pt, s2, pre);
    end
    tick("burst_end");
    ck = (n == 1) ? 1 : n - 1;
    if (ck > DEPTH) ck = DEPTH;
    chk_fifo("burst_end", ck);
    Data_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) tick(tag);
    tick({tag, "_idle"});
    tick({tag, "_idle"});
    chk_fifo({tag, "_idle"}, 0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    tick("reset");
    chk_fifo("reset", 0);
    rst = 1'b0;
    tick("post_reset");

    // Plain 8N1 at one clock per bit.
    wbuf[0] = 8'h81;
    send_burst(1, 1'b0, 1'b0, 1'b0, 0);
    drain("t1");

    // Odd parity, four clocks per bit.
    wbuf[0] = 8'h81;
    send_burst(1, 1'b1, 1'b1, 1'b0, 3);
    drain("t2");

    // Even parity with two stop bits.
    wbuf[0] = 8'h86;
    send_burst(1, 1'b1, 1'b0, 1'b1, 0);
    drain("t3");

    // Overfill: sixth word arrives while full and must be dropped.
    wbuf[0] = 8'h7F; wbuf[1] = 8'h86; wbuf[2] = 8'h55;
    wbuf[3] = 8'hAA; wbuf[4] = 8'h11; wbuf[5] = 8'h22;
    send_burst(6, 1'b0, 1'b0, 1'b0, 0);
    drain("t4");

    // Configuration changed mid-frame only affects the following frame.
    wbuf[0] = 8'h55;
    send_burst(1, 1'b0, 1'b0, 1'b0, 1);
    repeat (8) tick("t5a");
    PAR_EN   = 1'b1;
    Prescale = 8'd5;
    drain("t5a");
    wbuf[0] = 8'hC3;
    send_burst(1, 1'b1, 1'b0, 1'b0, 5);
    drain("t5b");

    // Reset during data bit 3 of the first of three queued frames.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; wbuf[2] = 8'hF0;
    send_burst(3, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) tick("t6");
    rst = 1'b1;
    exp_q.delete();
    tick("t6_rst");
    chk_fifo("t6_rst", 0);
    rst = 1'b0;
    repeat (30) tick("t6_quiet");
    chk_fifo("t6_quiet", 0);

    // Randomized bursts and configurations.
    for (int it = 0; it < 20; it++) begin
      int n;
      n = $urandom_range(1, DEPTH + 1);
      for (int k = 0; k < n; k++) wbuf[k] = DW'($urandom);
      send_burst(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      drain("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
